imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Sequences start-up of the single-cycle RISC-V core: holds the core in reset and receives a program image as a byte stream (valid/ready).
- Assembles little-endian 32-bit words and writes them into instruction memory through a dedicated write port.
- Verifies an XOR checksum, then releases the core.
- Sits between the host byte link (UART receiver), the IMEM write port and the core reset input.

Parameters:
ADDR_W, 10, IMEM word-address width; capacity DEPTH = 2**ADDR_W words

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  single-cycle pulse requesting a (re)load
rx_valid  input  1  byte available on rx_data
rx_data  input  8  incoming image byte
rx_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  IMEM word write strobe
imem_addr  output  ADDR_W  IMEM word address
imem_wdata  output  32  IMEM write data
core_hold  output  1  1 = core held in reset; drive core rst_n = ~core_hold
busy  output  1  load in progress
done  output  1  image verified, core running
err  output  1  load failed
words_loaded  output  16  words written in current or last load

Behaviour:
- Image format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N payload bytes (each word little-endian, first byte = bits 7:0), then 1 checksum byte = XOR of all payload bytes.
- A byte transfers when rx_valid and rx_ready are both high on a rising edge.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK, RUN, ERROR.
- Reset value of outputs: state IDLE, core_hold=1, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, words_loaded=0, checksum=0. Reset dominates every other input in the same cycle.
- rx_ready=1 only in LEN_LO, LEN_HI, DATA and CHECK. It is combinational from state.
- busy=1 in LEN_LO, LEN_HI, DATA and CHECK.
- core_hold=0 only in RUN. done=1 only in RUN. err=1 only in ERROR.
- Transition on start in IDLE, RUN or ERROR: go to LEN_LO; clear words_loaded, checksum, byte index and err/done; core_hold returns to 1 on the next cycle. start is ignored while busy.
- LEN_LO to LEN_HI on transfer.
- LEN_HI on transfer:
  - N=0: go to CHECK.
  - N>DEPTH: go to ERROR.
  - Otherwise: go to DATA.
- DATA:
  - Each transfer XORs the byte into checksum and places it in lane byte_idx (0..3) of the word buffer.
  - On the transfer with byte_idx=3, in the next cycle: imem_we=1 for exactly one cycle, imem_addr = word index, imem_wdata = completed word; words_loaded increments in that same cycle.
  - The byte index wraps to 0. Byte acceptance continues with no bubble, so back-to-back bytes are legal.
  - After the 4th byte of word N-1, go to CHECK. The final write strobe occurs during the first CHECK cycle.
- CHECK on transfer: byte equal to checksum goes to RUN, otherwise to ERROR.
- imem_addr and imem_wdata hold their last value when imem_we=0.
- Word index never exceeds DEPTH-1; this is guaranteed by the length check.
- Reset mid-load returns to IDLE with the core held. IMEM contents already written are not cleared.

Test Plan:
- ADDR_W=4, start, bytes 02 00 13 05 10 00 93 05 20 00 B0 with rx_valid held high -> imem_we pulses twice: addr 0 data 00100513, addr 1 data 00200593; words_loaded=2; done=1, core_hold=0 the cycle after B0 is accepted.
- Same image with checksum byte B1 -> err=1, core_hold stays 1, done=0; a later start pulse -> LEN_LO, err=0, busy=1.
- Length bytes 00 00 then checksum 00 -> RUN with no imem_we; length 00 00 then checksum 5A -> ERROR.
- ADDR_W=4, length 11 00 (17 words) -> ERROR immediately after LEN_HI, rx_ready=0, no imem_we.
- First image sent with rx_valid toggling 1/0 every cycle, plus a start pulse mid-DATA -> identical writes and result; the mid-load start is ignored.
- rst asserted after 6 payload bytes -> next cycle IDLE, all outputs at reset values, core_hold=1; subsequent full load succeeds.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: holds the core in reset, streams a length-prefixed image into IMEM,
// verifies the XOR checksum of the payload, then releases the core.
module imem_boot_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [15:0]         r_len;
    logic [7:0]          r_csum;
    logic [1:0]          r_bidx;
    logic [23:0]         r_buf;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [15:0]         r_words;

    logic                w_xfer;
    logic                w_restart;
    logic [15:0]         w_len_full;
    logic                w_len_big;
    logic                w_last_word;

    assign w_xfer      = rx_valid && rx_ready;
    assign w_restart   = start && (r_state == S_IDLE || r_state == S_RUN || r_state == S_ERROR);
    assign w_len_full  = {rx_data, r_len[7:0]};
    assign w_len_big   = 32'(w_len_full) > DEPTH;
    // r_words already counts every completed word, so it doubles as the word index
    assign w_last_word = (r_bidx == 2'd3) && (r_words == r_len - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        rx_ready    = 1'b0;
        busy        = 1'b0;
        core_hold   = 1'b1;
        done        = 1'b0;
        err         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (w_xfer) w_state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (w_xfer) begin
                    if (w_len_full == 16'd0) begin
                        w_state_nxt = S_CHECK;
                    end else if (w_len_big) begin
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (w_xfer && w_last_word) w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (w_xfer) w_state_nxt = (rx_data == r_csum) ? S_RUN : S_ERROR;
            end
            S_RUN: begin
                core_hold = 1'b0;
                done      = 1'b1;
                if (start) w_state_nxt = S_LEN_LO;
            end
            S_ERROR: begin
                err = 1'b1;
                if (start) w_state_nxt = S_LEN_LO;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len   <= '0;
            r_csum  <= '0;
            r_bidx  <= '0;
            r_buf   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_words <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_restart) begin
                r_csum  <= '0;
                r_bidx  <= '0;
                r_words <= '0;
            end
            if (w_xfer) begin
                case (r_state)
                    S_LEN_LO: r_len[7:0]  <= rx_data;
                    S_LEN_HI: r_len[15:8] <= rx_data;
                    S_DATA: begin
                        r_csum <= r_csum ^ rx_data;
                        r_bidx <= r_bidx + 2'd1;
                        case (r_bidx)
                            2'd0: r_buf[7:0]   <= rx_data;
                            2'd1: r_buf[15:8]  <= rx_data;
                            2'd2: r_buf[23:16] <= rx_data;
                            default: begin
                                r_we    <= 1'b1;
                                r_addr  <= r_words[ADDR_W-1:0];
                                r_wdata <= {rx_data, r_buf};
                                r_words <= r_words + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader (ADDR_W=4) with hand-computed expected values.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  tx[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    imem_boot_loader #(.ADDR_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_hold    (core_hold),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(32'(imem_addr));
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
    endtask

    // Sends tx[] bytes; with gap=1 rx_valid drops for one cycle before every byte.
    task automatic send_q(input bit gap);
        int n;
        for (int i = 0; i < tx.size(); i++) begin
            if (gap) begin
                rx_valid = 1'b0;
                @(negedge clk);
            end
            rx_valid = 1'b1;
            rx_data  = tx[i];
            n = 0;
            while (!rx_ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("rx_ready_wait", 32'(rx_ready), 32'd1);
            if (!rx_ready) begin
                rx_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic check_img1(input string tag);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_hold"}, 32'(core_hold), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd2);
        check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check({tag, "_a0"}, wr_addr[0], 32'd0);
            check({tag, "_d0"}, wr_data[0], 32'h0010_0513);
            check({tag, "_a1"}, wr_addr[1], 32'd1);
            check({tag, "_d1"}, wr_data[1], 32'h0020_0593);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, 32'(core_hold), 32'd1);
        check({tag, "_rdy"}, 32'(rx_ready), 32'd0);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_outs("rst");
        rst = 1'b0;
        @(negedge clk);

        // Image 1 back-to-back
        clear_writes();
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_rdy", 32'(rx_ready), 32'd1);
        check("t1_hold", 32'(core_hold), 32'd1);
        tx = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
        send_q(1'b0);
        check_img1("t1");

        // Bad checksum, then restart
        clear_writes();
        pulse_start();
        check("t2_hold_after_start", 32'(core_hold), 32'd1);
        tx = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB1};
        send_q(1'b0);
        check("t2_err", 32'(err), 32'd1);
        check("t2_hold", 32'(core_hold), 32'd1);
        check("t2_done", 32'(done), 32'd0);
        pulse_start();
        check("t2r_err", 32'(err), 32'd0);
        check("t2r_busy", 32'(busy), 32'd1);
        check("t2r_words", 32'(words_loaded), 32'd0);

        // Zero-length image from the restarted load
        clear_writes();
        tx = '{8'h00, 8'h00, 8'h00};
        send_q(1'b0);
        check("t3_done", 32'(done), 32'd1);
        check("t3_nwr", 32'(wr_addr.size()), 32'd0);
        pulse_start();
        tx = '{8'h00, 8'h00, 8'h5A};
        send_q(1'b0);
        check("t3b_err", 32'(err), 32'd1);
        check("t3b_done", 32'(done), 32'd0);

        // Oversized length: 17 words into a 16-word IMEM
        clear_writes();
        pulse_start();
        tx = '{8'h11, 8'h00};
        send_q(1'b0);
        check("t4_err", 32'(err), 32'd1);
        check("t4_rdy", 32'(rx_ready), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_nwr", 32'(wr_addr.size()), 32'd0);

        // Throttled stream with a start pulse mid-DATA
        clear_writes();
        pulse_start();
        tx = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
        fork
            send_q(1'b1);
            begin
                repeat (12) @(negedge clk);
                pulse_start();
            end
        join
        check_img1("t5");
        check("t5_err", 32'(err), 32'd0);

        // Reset after 6 payload bytes, then a full load
        clear_writes();
        pulse_start();
        tx = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05};
        send_q(1'b0);
        check("t6_words_pre", 32'(words_loaded), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outs("t6_rst");
        rst = 1'b0;
        @(negedge clk);
        clear_writes();
        pulse_start();
        tx = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
        send_q(1'b0);
        check_img1("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
